// File: rtl/mode_select.sv
// Mode selector: three push buttons are synchronized and debounced, and a
// two-state controller turns a single clean press into a one-hot mode code.
module mode_select #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_free,
  input  logic       btn_auto,
  input  logic       btn_learn,
  input  logic       lock,
  output logic [2:0] mode_code,
  output logic       mode_change,
  output logic [2:0] btn_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_e;

  logic [2:0] btn_raw;
  logic [2:0] stable_vec;
  logic [2:0] stable_prev_q;
  logic [2:0] press;
  logic       single_press;
  state_e     state_q;
  logic [2:0] mode_code_q;
  logic       mode_change_q;

  assign btn_raw = {btn_learn, btn_auto, btn_free};

  // One synchronizer + debouncer per button; bit order is {learn, auto, free}.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
        if (cnt_q == CNT_MAX) begin
          stable_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= btn_raw[gi];
        sync2_q  <= sync1_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign stable_vec[gi] = stable_q;
  end

  assign press        = stable_vec & ~stable_prev_q;
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign single_press = (press != 3'b000) && ((press & (press - 3'd1)) == 3'b000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      stable_prev_q <= 3'b000;
      mode_code_q   <= 3'b001;
      mode_change_q <= 1'b0;
    end else begin
      stable_prev_q <= stable_vec;
      mode_change_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (single_press && !lock) begin
            mode_code_q   <= press;
            mode_change_q <= (press != mode_code_q);
          end
          if (stable_vec != 3'b000) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (stable_vec == 3'b000) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mode_code   = mode_code_q;
  assign mode_change = mode_change_q;
  assign btn_level   = stable_vec;

endmodule

// File: tb/tb_mode_select.sv
// Randomized and directed bench for mode_select, checked every cycle against
// a sample-history reference model of the buttons and mode rules.
module tb_mode_select;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       btn_free;
  logic       btn_auto;
  logic       btn_learn;
  logic       lock;
  logic [2:0] mode_code;
  logic       mode_change;
  logic [2:0] btn_level;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [2:0]   m_sync1, m_sync2, m_stable, m_prev, m_mode;
  logic [D-1:0] m_hist [3];
  logic         m_chg, m_hold;

  mode_select #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_free   (btn_free),
    .btn_auto   (btn_auto),
    .btn_learn  (btn_learn),
    .lock       (lock),
    .mode_code  (mode_code),
    .mode_change(mode_change),
    .btn_level  (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // A level is accepted once the last D synchronized samples all disagree
  // with it; a press is a 0->1 of the accepted level; only one lone press
  // while no button is held (and lock low) selects a mode.
  task automatic model_step(input logic r, input logic [2:0] raw, input logic lk);
    logic [2:0] pr;
    if (r) begin
      m_sync1 = '0; m_sync2 = '0; m_stable = '0; m_prev = '0;
      m_mode = 3'b001; m_chg = 1'b0; m_hold = 1'b0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
      return;
    end
    pr    = m_stable & ~m_prev;
    m_chg = 1'b0;
    if (!m_hold) begin
      if ($countones(pr) == 1 && !lk) begin
        m_chg  = (pr != m_mode);
        m_mode = pr;
      end
      if (m_stable != 3'b000) m_hold = 1'b1;
    end else if (m_stable == 3'b000) begin
      m_hold = 1'b0;
    end
    m_prev = m_stable;
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = {m_hist[b][D-2:0], m_sync2[b]};
      if (m_hist[b] == {D{~m_stable[b]}}) m_stable[b] = ~m_stable[b];
    end
    m_sync2 = m_sync1;
    m_sync1 = raw;
  endtask

  // Apply inputs for one edge, advance the model, compare just after the edge.
  task automatic cycle(input logic r, input logic [2:0] b, input logic lk);
    rst = r; btn_learn = b[2]; btn_auto = b[1]; btn_free = b[0]; lock = lk;
    @(posedge clk);
    model_step(r, b, lk);
    #1;
    check("mode_code", mode_code, m_mode);
    check("mode_change", mode_change, m_chg);
    check("btn_level", btn_level, m_stable);
    check("onehot", $countones(mode_code), 1);
  endtask

  task automatic hold_for(input logic r, input logic [2:0] b, input logic lk, input int n);
    for (int i = 0; i < n; i++) cycle(r, b, lk);
  endtask

  initial begin
    rst = 1'b1; btn_free = 0; btn_auto = 0; btn_learn = 0; lock = 0;
    hold_for(1, 3'b000, 0, 3);
    check("reset_mode", mode_code, 3'b001);
    check("reset_level", btn_level, 3'b000);
    check("reset_chg", mode_change, 1'b0);
    $display("txn reset: mode=%b lvl=%b", mode_code, btn_level);

    // Short learn glitch.
    hold_for(0, 3'b100, 0, 3);
    hold_for(0, 3'b000, 0, 10);
    check("glitch_mode", mode_code, 3'b001);
    check("glitch_level", btn_level, 3'b000);
    $display("txn glitch: mode=%b lvl=%b", mode_code, btn_level);

    // Auto press latency from reset.
    hold_for(1, 3'b000, 0, 2);
    hold_for(0, 3'b010, 0, 5);
    check("lat_lvl_e5", btn_level, 3'b000);
    cycle(0, 3'b010, 0);
    check("lat_lvl_e6", btn_level, 3'b010);
    check("lat_mode_e6", mode_code, 3'b001);
    cycle(0, 3'b010, 0);
    check("lat_mode_e7", mode_code, 3'b010);
    check("lat_chg_e7", mode_change, 1'b1);
    cycle(0, 3'b010, 0);
    check("lat_chg_e8", mode_change, 1'b0);
    hold_for(0, 3'b000, 0, 8);
    $display("txn latency: mode=%b", mode_code);

    // Simultaneous free+learn, then learn alone.
    hold_for(0, 3'b101, 0, 10);
    check("dual_mode", mode_code, 3'b010);
    hold_for(0, 3'b000, 0, 8);
    hold_for(0, 3'b100, 0, 8);
    check("learn_mode", mode_code, 3'b100);
    hold_for(0, 3'b000, 0, 8);
    $display("txn dual: mode=%b", mode_code);

    // Locked press is discarded, not queued.
    hold_for(0, 3'b010, 1, 8);
    hold_for(0, 3'b010, 0, 4);
    check("lock_mode", mode_code, 3'b100);
    hold_for(0, 3'b000, 0, 8);
    hold_for(0, 3'b010, 0, 8);
    check("unlock_mode", mode_code, 3'b010);
    hold_for(0, 3'b000, 0, 8);
    $display("txn lock: mode=%b", mode_code);

    // Re-press current mode; second button while held.
    hold_for(1, 3'b000, 0, 2);
    hold_for(0, 3'b001, 0, 8);
    check("repress_mode", mode_code, 3'b001);
    hold_for(0, 3'b011, 0, 8);
    check("hold_ignore", mode_code, 3'b001);
    hold_for(0, 3'b000, 0, 8);
    $display("txn repress: mode=%b", mode_code);

    // Reset mid-debounce with learn still held.
    hold_for(0, 3'b100, 0, 4);
    cycle(1, 3'b100, 0);
    check("midrst_mode", mode_code, 3'b001);
    check("midrst_level", btn_level, 3'b000);
    hold_for(0, 3'b100, 0, 2 + D);
    check("midrst_e6", mode_code, 3'b001);
    cycle(0, 3'b100, 0);
    check("midrst_e7", mode_code, 3'b100);
    hold_for(0, 3'b000, 0, 8);
    $display("txn midreset: mode=%b", mode_code);

    // Randomized segments.
    for (int s = 0; s < 250; s++) begin
      logic [2:0] b;
      logic       lk, r;
      int         len;
      b   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) b = 3'b000;
      lk  = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 40) == 0);
      len = r ? 1 : $urandom_range(1, 12);
      hold_for(r, b, lk, len);
      $display("txn rand %0d: rst=%b btn=%b lock=%b len=%0d mode=%b lvl=%b",
               s, r, b, lk, len, mode_code, btn_level);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
